pipe_hazard_ctrl: RTL

Central stall/flush controller for the five-stage MIPS pipeline with split I/D caches. Produces the write enables and flush strobes for PC, IF/ID, ID/EX, EX/M and M/WB registers. Arbitrates the single shared refill port between I-cache and D-cache misses. Counts stall cycles for performance measurement.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/load_use_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline stall/flush controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_FILL = 2'd1,
    I_FILL = 2'd2
  } state_t;

  localparam logic MEM_SEL_I = 1'b0;
  localparam logic MEM_SEL_D = 1'b1;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags a load in EX whose result an ID source needs
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WR_out,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  output logic             hazard
);

  // $zero never carries a real dependency
  assign hazard = EX_MemRead && (EX_WR_out != '0) &&
                  ((EX_WR_out == ID_Rs) || (EX_WR_out == ID_Rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush decode, shared refill arbitration, stall counter
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WR_out,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_BranchTaken,
  input  logic             ic_miss,
  input  logic             dc_miss,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             ID_EXWrite,
  output logic             EX_MWrite,
  output logic             M_WBWrite,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t state, next_state;
  logic   load_use;
  logic   d_stall, i_stall;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .EX_MemRead (EX_MemRead),
    .EX_WR_out  (EX_WR_out),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .hazard     (load_use)
  );

  // D fill wins arbitration; a pending miss of the other side chains on the ack
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (dc_miss) next_state = D_FILL;
               else if (ic_miss) next_state = I_FILL;
      D_FILL:  if (mem_ack) next_state = ic_miss ? I_FILL : IDLE;
      I_FILL:  if (mem_ack) next_state = dc_miss ? D_FILL : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_sel <= MEM_SEL_I;
    end else begin
      state   <= next_state;
      mem_req <= (next_state != IDLE);
      mem_sel <= (next_state == D_FILL) ? MEM_SEL_D : MEM_SEL_I;
    end
  end

  assign d_stall = (state == D_FILL) || ((state == IDLE) && dc_miss);
  assign i_stall = (state == I_FILL) || ((state == IDLE) && ic_miss);

  always_comb begin
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXWrite = 1'b1;
    EX_MWrite  = 1'b1;
    M_WBWrite  = 1'b1;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    if (d_stall) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
      EX_MWrite  = 1'b0;
      M_WBWrite  = 1'b0;
    end else if (i_stall || load_use) begin
      // front end holds while a bubble lets older instructions drain
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_Flush   = 1'b1;
    end else if (ID_BranchTaken) begin
      IF_Flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!PCWrite && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
